// File: rtl/regfile_stream_master.sv
// regfile_stream_master
// Debug-path initiator for the 32x32 RV32 register file. DUMP commands read a
// contiguous (mod-32) register range and stream it out; LOAD commands take a
// stream of words and write them into a contiguous register range.
module regfile_stream_master #(
    parameter int N = 32,
    parameter int A = 5
) (
    input  logic         clk,
    input  logic         rst,
    // command channel
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_op,
    input  logic [A-1:0] cmd_first,
    input  logic [5:0]   cmd_count,
    // dump output stream
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [A-1:0] out_addr,
    // load input stream
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    // register file read port
    output logic [A-1:0] rd_addr,
    input  logic [N-1:0] rd_data,
    // register file write port
    output logic         wr_ena,
    output logic [A-1:0] wr_addr,
    output logic [N-1:0] wr_data,
    // status
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DUMP  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] addr_q, addr_d;
    logic [5:0]   rem_q, rem_d;
    logic         wr_ena_q, wr_ena_d;
    logic [A-1:0] wr_addr_q, wr_addr_d;
    logic [N-1:0] wr_data_q, wr_data_d;

    logic cmd_fire;
    logic out_fire;
    logic in_fire;
    logic last_word;

    // Handshake qualifiers, decoded from the current state only so that no
    // valid output depends combinationally on its own ready input.
    always_comb begin
        cmd_fire  = cmd_valid && (state_q == ST_IDLE);
        out_fire  = out_ready && (state_q == ST_DUMP);
        in_fire   = in_valid  && (state_q == ST_LOAD);
        last_word = (rem_q == 6'd1);
    end

    // State register and datapath flops; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wr_ena_q  <= wr_ena_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state logic: a zero-length command goes straight to FIN so it still
    // produces its done pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_count == 6'd0) begin
                        state_d = ST_FIN;
                    end else if (cmd_op) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DUMP;
                    end
                end
            end
            ST_DUMP: begin
                if (out_fire && last_word) begin
                    state_d = ST_FIN;
                end
            end
            ST_LOAD: begin
                if (in_fire && last_word) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Address/count tracking and the registered write port. Address wraps
    // modulo 32 naturally through the A-bit adder.
    always_comb begin
        addr_d    = addr_q;
        rem_d     = rem_q;
        wr_ena_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire && (cmd_count != 6'd0)) begin
                    addr_d = cmd_first;
                    rem_d  = cmd_count;
                end
            end
            ST_DUMP: begin
                if (out_fire) begin
                    addr_d = addr_q + A'(1);
                    rem_d  = rem_q - 6'd1;
                end
            end
            ST_LOAD: begin
                if (in_fire) begin
                    wr_ena_d  = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    addr_d    = addr_q + A'(1);
                    rem_d     = rem_q - 6'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Moore outputs decoded from the state; dump data is the register file
    // read data passed straight through, so it is stable while addr is held.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        out_valid = (state_q == ST_DUMP);
        in_ready  = (state_q == ST_LOAD);
        out_data  = (state_q == ST_DUMP) ? rd_data : '0;
        out_addr  = addr_q;
        rd_addr   = addr_q;
        wr_ena    = wr_ena_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
    end

endmodule

// File: tb/tb_regfile_stream_master.sv
// Testbench for regfile_stream_master: hosts a behavioural register file and
// compares every transaction against a flat array model of the register file.
module tb_regfile_stream_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [4:0]  cmd_first;
    logic [5:0]  cmd_count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [31:0] rf [32];      // register file the DUT drives
    logic [31:0] exp_rf [32];  // expected architectural contents
    logic [31:0] ld [32];      // words to load in the next LOAD
    logic [36:0] wr_log [$];   // every write issued, {addr, data}

    regfile_stream_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_first(cmd_first), .cmd_count(cmd_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: x0 hardwired to zero, combinational read.
    assign rd_data = (rd_addr == 5'd0) ? 32'd0 : rf[rd_addr];
    always @(posedge clk) begin
        if (wr_ena && (wr_addr != 5'd0)) rf[wr_addr] <= wr_data;
    end

    // Mid-cycle observers of write traffic and completion pulses.
    always @(negedge clk) begin
        if (wr_ena) wr_log.push_back({wr_addr, wr_data});
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [31:0] expv(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : exp_rf[a];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic op, input logic [4:0] first, input int count);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_first = first;
        cmd_count = 6'(count);
        step();
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom_range(0, 1));
        cmd_first = 5'($urandom_range(0, 31));
        cmd_count = 6'($urandom_range(0, 32));
    endtask

    // LOAD ld[0..count-1] into first.. ; optionally idle in_valid every third cycle.
    task automatic do_load(input logic [4:0] first, input int count, input bit gap);
        int sent = 0;
        int cyc = 0;
        int base;
        int d0;
        bit prev_acc = 1'b0;
        logic [4:0]  pa = '0;
        logic [31:0] pd = '0;
        base = wr_log.size();
        d0 = done_cnt;
        issue(1'b1, first, count);
        while (sent < count && cyc < 200) begin
            chk("load_wr_ena", wr_ena, prev_acc);
            if (prev_acc) begin
                chk("load_wr_addr", wr_addr, pa);
                chk("load_wr_data", wr_data, pd);
            end
            chk("load_in_ready", in_ready, 1);
            if (gap && (cyc % 3 == 2)) begin
                in_valid = 1'b0;
                prev_acc = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = ld[sent];
                prev_acc = 1'b1;
                pa = 5'(first + sent);
                pd = ld[sent];
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        chk("load_words_sent", sent, count);
        // final write issues while the block drains
        chk("drain_busy", busy, 1);
        chk("drain_in_ready", in_ready, 0);
        chk("drain_wr_ena", wr_ena, 1);
        chk("drain_wr_addr", wr_addr, pa);
        chk("drain_wr_data", wr_data, pd);
        chk("drain_done", done, 0);
        step();
        chk("load_fin_done", done, 1);
        chk("load_fin_wr_ena", wr_ena, 0);
        chk("load_fin_cmd_ready", cmd_ready, 0);
        step();
        chk("load_idle_busy", busy, 0);
        chk("load_idle_done", done, 0);
        chk("load_write_count", wr_log.size() - base, count);
        chk("load_done_pulses", done_cnt - d0, 1);
        for (int i = 0; i < count; i++) exp_rf[5'(first + i)] = ld[i];
    endtask

    // DUMP first.. ; mode 0: always ready, 1: ready 1,0,0,1 repeating, 2: random.
    task automatic do_dump(input logic [4:0] first, input int count, input int mode);
        int got = 0;
        int cyc = 0;
        int d0;
        bit stall = 1'b0;
        logic [4:0]  ha = '0;
        logic [31:0] hd = '0;
        logic [4:0]  ea;
        d0 = done_cnt;
        issue(1'b0, first, count);
        while (got < count && cyc < 400) begin
            ea = 5'(first + got);
            chk("dump_out_valid", out_valid, 1);
            chk("dump_wr_ena", wr_ena, 0);
            chk("dump_in_ready", in_ready, 0);
            if (stall) begin
                chk("stall_addr_hold", out_addr, ha);
                chk("stall_data_hold", out_data, hd);
            end
            chk("dump_out_addr", out_addr, ea);
            chk("dump_rd_addr", rd_addr, ea);
            chk("dump_out_data", out_data, expv(ea));
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_ready) got++;
            stall = !out_ready;
            ha = out_addr;
            hd = out_data;
            step();
            cyc++;
        end
        out_ready = 1'($urandom_range(0, 1));
        chk("dump_beats", got, count);
        chk("dump_fin_done", done, 1);
        chk("dump_fin_out_valid", out_valid, 0);
        chk("dump_fin_busy", busy, 1);
        step();
        chk("dump_idle_busy", busy, 0);
        chk("dump_done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        int base;
        int d0;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_first = '0; cmd_count = '0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        step(); step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ena", wr_ena, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b1;
        step();

        // whole file, gapped input, then a full readback
        for (int i = 0; i < 32; i++) ld[i] = $urandom;
        do_load(5'd0, 32, 1'b1);
        do_dump(5'd0, 32, 0);

        // x5/x6 preload and readback
        ld[0] = 32'hDEADBEEF; ld[1] = 32'h12345678;
        do_load(5'd5, 2, 1'b0);
        do_dump(5'd5, 2, 0);

        // wrap through x0
        ld[0] = 32'd30; ld[1] = 32'd31; ld[2] = 32'd99; ld[3] = 32'd1;
        do_load(5'd30, 4, 1'b0);
        do_dump(5'd30, 4, 0);

        // back-pressure
        do_dump(5'd3, 7, 1);
        do_dump(5'($urandom_range(0, 31)), $urandom_range(1, 32), 2);
        for (int i = 0; i < 32; i++) ld[i] = $urandom;
        do_load(5'($urandom_range(0, 31)), $urandom_range(1, 32), 1'b1);
        do_dump(5'($urandom_range(0, 31)), 32, 2);

        // zero-length commands of both kinds
        for (int op = 0; op < 2; op++) begin
            base = wr_log.size();
            d0 = done_cnt;
            issue(1'(op), 5'd7, 0);
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 1);
            chk("zero_cmd_ready", cmd_ready, 0);
            chk("zero_out_valid", out_valid, 0);
            chk("zero_in_ready", in_ready, 0);
            chk("zero_wr_ena", wr_ena, 0);
            step();
            chk("zero_idle_busy", busy, 0);
            chk("zero_idle_done", done, 0);
            chk("zero_no_writes", wr_log.size() - base, 0);
            chk("zero_done_pulses", done_cnt - d0, 1);
        end

        // reset in the middle of a LOAD after three words
        for (int i = 0; i < 8; i++) ld[i] = $urandom;
        base = wr_log.size();
        d0 = done_cnt;
        issue(1'b1, 5'd10, 8);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = ld[i];
            step();
            chk("mid_wr_ena", wr_ena, 1);
            chk("mid_wr_addr", wr_addr, 5'(10 + i));
            chk("mid_wr_data", wr_data, ld[i]);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_wr_ena", wr_ena, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_wr_data", wr_data, 0);
        chk("abort_rd_addr", rd_addr, 0);
        chk("abort_done", done, 0);
        rst = 1'b1;
        step();
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_writes", wr_log.size() - base, 3);
        chk("abort_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 3; i++) exp_rf[10 + i] = ld[i];
        do_dump(5'd10, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
